// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the instruction cache and
// the data cache. One cache owns the memory at a time and keeps it for the
// whole burst. A cache that is waiting for ownership sees 'stall' high.
//
// Tie-breaking between simultaneous requests is selected at build time:
//   ARB_ROUND_ROBIN_EN defined   : the port not granted most recently wins.
//   ARB_ROUND_ROBIN_EN undefined : fixed priority, the dcache always wins.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   // icache memory-side port
   input  logic                  i_mreq,
   input  logic [ADDR_WIDTH-1:0] i_maddr,
   input  logic [DATA_WIDTH-1:0] i_mwrite_data,
   input  logic                  i_m_wen,
   output logic [DATA_WIDTH-1:0] i_mread_data,
   output logic                  i_mready,
   // dcache memory-side port
   input  logic                  d_mreq,
   input  logic [ADDR_WIDTH-1:0] d_maddr,
   input  logic [DATA_WIDTH-1:0] d_mwrite_data,
   input  logic                  d_m_wen,
   output logic [DATA_WIDTH-1:0] d_mread_data,
   output logic                  d_mready,
   // shared main memory
   output logic                  m_req,
   output logic [ADDR_WIDTH-1:0] maddr,
   output logic [DATA_WIDTH-1:0] mwrite_data,
   output logic                  m_wen,
   input  logic [DATA_WIDTH-1:0] mread_data,
   input  logic                  mready,
   // status
   output logic                  stall,
   output logic [1:0]            grant
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_I = 2'b01,
      GNT_D = 2'b10
   } state_t;

   state_t state;
   state_t next_state;
   logic   tie_to_d;

`ifdef ARB_ROUND_ROBIN_EN
   // 0 = icache was granted most recently, 1 = dcache
   logic last;
   assign tie_to_d = ~last;
`else
   assign tie_to_d = 1'b1;
`endif

   // Pick the next owner: bursts are never preempted, and a released port
   // hands over directly to a waiting one without passing through IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (d_mreq && (!i_mreq || tie_to_d)) begin
               next_state = GNT_D;
            end else if (i_mreq) begin
               next_state = GNT_I;
            end else begin
               next_state = IDLE;
            end
         end
         GNT_I: begin
            if (!i_mreq) begin
               next_state = d_mreq ? GNT_D : IDLE;
            end
         end
         GNT_D: begin
            if (!d_mreq) begin
               next_state = i_mreq ? GNT_I : IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Owner register, registered one-hot grant and (optionally) the
   // round-robin history; reset wins over every transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         grant <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
         last  <= 1'b0;
`endif
      end else begin
         state <= next_state;
         case (next_state)
            GNT_I:   grant <= 2'b01;
            GNT_D:   grant <= 2'b10;
            default: grant <= 2'b00;
         endcase
`ifdef ARB_ROUND_ROBIN_EN
         if (next_state == GNT_I) begin
            last <= 1'b0;
         end else if (next_state == GNT_D) begin
            last <= 1'b1;
         end
`endif
      end
   end

   // Route the owner's port to memory; everything else is held at zero so a
   // non-owner never sees a stray ready or read data.
   always_comb begin
      m_req        = 1'b0;
      maddr        = '0;
      mwrite_data  = '0;
      m_wen        = 1'b0;
      i_mready     = 1'b0;
      d_mready     = 1'b0;
      i_mread_data = '0;
      d_mread_data = '0;
      case (state)
         GNT_I: begin
            m_req        = i_mreq;
            maddr        = i_maddr;
            mwrite_data  = i_mwrite_data;
            m_wen        = i_m_wen & i_mreq;
            i_mready     = mready & i_mreq;
            i_mread_data = mread_data;
         end
         GNT_D: begin
            m_req        = d_mreq;
            maddr        = d_maddr;
            mwrite_data  = d_mwrite_data;
            m_wen        = d_m_wen & d_mreq;
            d_mready     = mready & d_mreq;
            d_mread_data = mread_data;
         end
         default: begin
         end
      endcase
   end

   // A cache is stalled whenever it asks for memory it does not own.
   assign stall = (i_mreq & ~grant[0]) | (d_mreq & ~grant[1]);

   // Structural invariants of the arbiter outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(m_wen && !m_req));
         assert (grant != 2'b11);
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a scoreboard.
// Every word the stimulus completes with mready pushes the expected transfer;
// a monitor pops it when the DUT pulses a cache-side ready.
module tb_mem_arbiter;

   localparam logic [1:0] GN = 2'b00;
   localparam logic [1:0] GI = 2'b01;
   localparam logic [1:0] GD = 2'b10;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_mreq, i_m_wen, i_mready;
   logic [31:0] i_maddr, i_mwrite_data, i_mread_data;
   logic        d_mreq, d_m_wen, d_mready;
   logic [31:0] d_maddr, d_mwrite_data, d_mread_data;
   logic        m_req, m_wen, mready, stall;
   logic [31:0] maddr, mwrite_data, mread_data;
   logic [1:0]  grant;

   typedef struct {
      logic [1:0]  port;
      logic [31:0] addr;
      logic        wen;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .i_mreq(i_mreq), .i_maddr(i_maddr), .i_mwrite_data(i_mwrite_data),
      .i_m_wen(i_m_wen), .i_mread_data(i_mread_data), .i_mready(i_mready),
      .d_mreq(d_mreq), .d_maddr(d_maddr), .d_mwrite_data(d_mwrite_data),
      .d_m_wen(d_m_wen), .d_mread_data(d_mread_data), .d_mready(d_mready),
      .m_req(m_req), .maddr(maddr), .mwrite_data(mwrite_data), .m_wen(m_wen),
      .mread_data(mread_data), .mready(mready),
      .stall(stall), .grant(grant)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memFn(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] wdataFn(input logic [31:0] a);
      return a + 32'h1111_0000;
   endfunction

   // Combinational memory: read data is a fixed function of the address.
   assign mread_data = memFn(maddr);

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Drives one cycle of inputs just after the rising edge, records the
   // expected transfer when memory completes a word, then waits for the
   // falling edge so the caller can sample settled outputs.
   task automatic applyStimulus(input logic rst,
                                input logic ireq, input logic iwen, input logic [31:0] iaddr,
                                input logic dreq, input logic dwen, input logic [31:0] daddr,
                                input logic rdy, input logic [1:0] owner);
      exp_t e;
      @(posedge clk);
      #1;
      reset         = rst;
      i_mreq        = ireq;
      i_m_wen       = iwen;
      i_maddr       = iaddr;
      i_mwrite_data = wdataFn(iaddr);
      d_mreq        = dreq;
      d_m_wen       = dwen;
      d_maddr       = daddr;
      d_mwrite_data = wdataFn(daddr);
      mready        = rdy;
      if (rdy) begin
         e.port = owner;
         e.addr = (owner == GI) ? iaddr : daddr;
         e.wen  = (owner == GI) ? iwen : dwen;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, GN);
   endtask

   // Scoreboard monitor: every cache-side ready must match the oldest
   // expected transfer in port, address, direction and data.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (i_mready || d_mready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_unexpected_ready actual=%b required=none",
                     {d_mready, i_mready});
         end else begin
            e = sb.pop_front();
            checkOutput("sb_ready", 32'({d_mready, i_mready}), 32'(e.port));
            checkOutput("sb_maddr", maddr, e.addr);
            checkOutput("sb_wen", 32'(m_wen), 32'(e.wen));
            if (e.wen) begin
               checkOutput("sb_wdata", mwrite_data, wdataFn(e.addr));
            end else if (e.port == GI) begin
               checkOutput("sb_rdata_i", i_mread_data, memFn(e.addr));
            end else begin
               checkOutput("sb_rdata_d", d_mread_data, memFn(e.addr));
            end
         end
      end
   end

   // Guard against a hung simulation.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0]  tieExp [6];
      int          iLeft;
      int          dLeft;
      logic [31:0] a;

      // Reset held for two edges with both caches requesting
      reset = 1'b1;
      i_mreq = 1'b1; i_m_wen = 1'b0; i_maddr = 32'h10; i_mwrite_data = 32'h0;
      d_mreq = 1'b1; d_m_wen = 1'b0; d_maddr = 32'h20; d_mwrite_data = 32'h0;
      mready = 1'b0;
      @(negedge clk);
      checkOutput("rst_grant", 32'(grant), 32'(GN));
      checkOutput("rst_m_req", 32'(m_req), 32'd0);
      checkOutput("rst_stall", 32'(stall), 32'd1);
      checkOutput("rst_maddr", maddr, 32'h0);
      checkOutput("rst_m_wen", 32'(m_wen), 32'd0);
      checkOutput("rst_ready", 32'({d_mready, i_mready}), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h20, 1'b0, GN);
      checkOutput("rst2_grant", 32'(grant), 32'(GN));
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h20, 1'b0, GN);
      checkOutput("rel_grant", 32'(grant), 32'(GD));
      checkOutput("rel_stall", 32'(stall), 32'd1);
      checkOutput("rel_maddr", maddr, 32'h20);
      checkOutput("rel_i_rdata", i_mread_data, 32'h0);
      idleCycle();
      checkOutput("rel_drop_m_req", 32'(m_req), 32'd0);
      idleCycle();
      checkOutput("rel_idle_grant", 32'(grant), 32'(GN));

      // Single icache burst of four words, memory ready every second cycle
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, GN);
      checkOutput("ib_req_grant", 32'(grant), 32'(GN));
      checkOutput("ib_req_stall", 32'(stall), 32'd1);
      for (int w = 0; w < 4; w++) begin
         a = 32'h100 + 32'(4 * w);
         applyStimulus(1'b0, 1'b1, 1'b0, a, 1'b0, 1'b0, 32'h0, 1'b0, GN);
         checkOutput("ib_grant", 32'(grant), 32'(GI));
         checkOutput("ib_stall", 32'(stall), 32'd0);
         checkOutput("ib_maddr", maddr, a);
         applyStimulus(1'b0, 1'b1, 1'b0, a, 1'b0, 1'b0, 32'h0, 1'b1, GI);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h10C, 1'b0, 1'b0, 32'h0, 1'b0, GN);
      checkOutput("ib_end_m_req", 32'(m_req), 32'd0);
      idleCycle();
      checkOutput("ib_idle_grant", 32'(grant), 32'(GN));

      // Contention: dcache write waits behind an icache burst
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, GN);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1, GI);
      checkOutput("ct_grant0", 32'(grant), 32'(GI));
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h204, 1'b1, 1'b1, 32'h300, 1'b0, GN);
      checkOutput("ct_stall", 32'(stall), 32'd1);
      checkOutput("ct_m_wen", 32'(m_wen), 32'd0);
      checkOutput("ct_grant_locked", 32'(grant), 32'(GI));
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h204, 1'b1, 1'b1, 32'h300, 1'b1, GI);
      checkOutput("ct_stall2", 32'(stall), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h204, 1'b1, 1'b1, 32'h300, 1'b0, GN);
      checkOutput("ct_drop_grant", 32'(grant), 32'(GI));
      checkOutput("ct_drop_stall", 32'(stall), 32'd1);
      checkOutput("ct_drop_m_wen", 32'(m_wen), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b0, GN);
      checkOutput("ct_hand_grant", 32'(grant), 32'(GD));
      checkOutput("ct_hand_stall", 32'(stall), 32'd0);
      checkOutput("ct_hand_m_wen", 32'(m_wen), 32'd1);
      checkOutput("ct_hand_maddr", maddr, 32'h300);
      checkOutput("ct_hand_i_rdata", i_mread_data, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b1, GD);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0, GN);
      checkOutput("ct_end_m_wen", 32'(m_wen), 32'd0);
      idleCycle();
      checkOutput("ct_idle_grant", 32'(grant), 32'(GN));

      // Abort: dcache withdraws before memory completes the word
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 1'b0, GN);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 1'b0, GN);
      checkOutput("ab_m_req", 32'(m_req), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h500, 1'b0, GN);
      checkOutput("ab_drop_m_req", 32'(m_req), 32'd0);
      checkOutput("ab_drop_grant", 32'(grant), 32'(GD));
      idleCycle();
      checkOutput("ab_idle_grant", 32'(grant), 32'(GN));

      // Reset in the middle of a dcache write burst
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h600, 1'b0, GN);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h600, 1'b1, GD);
      checkOutput("rm_grant", 32'(grant), 32'(GD));
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h604, 1'b0, GN);
      checkOutput("rm_pre_m_wen", 32'(m_wen), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h604, 1'b0, GN);
      checkOutput("rm_post_grant", 32'(grant), 32'(GN));
      checkOutput("rm_post_m_wen", 32'(m_wen), 32'd0);
      checkOutput("rm_post_m_req", 32'(m_req), 32'd0);
      checkOutput("rm_post_stall", 32'(stall), 32'd1);
      idleCycle();
      checkOutput("rm_idle_grant", 32'(grant), 32'(GN));

      // Ties: both caches have three one-word bursts queued
`ifdef ARB_ROUND_ROBIN_EN
      tieExp = '{GD, GI, GD, GI, GD, GI};
`else
      tieExp = '{GD, GD, GD, GI, GI, GI};
`endif
      iLeft = 3;
      dLeft = 3;
      for (int r = 0; r < 6; r++) begin
         applyStimulus(1'b0, iLeft > 0, 1'b0, 32'h700 + 32'(16 * r),
                       dLeft > 0, 1'b0, 32'h800 + 32'(16 * r), 1'b0, GN);
         checkOutput("tie_idle_grant", 32'(grant), 32'(GN));
         applyStimulus(1'b0, iLeft > 0, 1'b0, 32'h700 + 32'(16 * r),
                       dLeft > 0, 1'b0, 32'h800 + 32'(16 * r), 1'b1, tieExp[r]);
         checkOutput("tie_grant", 32'(grant), 32'(tieExp[r]));
         if (tieExp[r] == GI) begin
            iLeft--;
         end else begin
            dLeft--;
         end
         idleCycle();
      end

      idleCycle();
      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
